onehot_seq_checker: RTL and testbench

ONEHOT_SEQ_CHECKER -- requirements
Module: onehot_seq_checker

---
 rtl/onehot_seq_checker_if.sv | 17 +
 rtl/onehot_seq_checker.sv | 149 ++++++++++++++
 tb/tb_onehot_seq_checker.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/onehot_seq_checker_if.sv
// rtl/onehot_seq_checker_if.sv - sample stream bundle for the one-hot sequence checker
//
// Ports (members):
//   valid   - data_in carries a sample this cycle
//   load    - sample is a parallel load; sequence restarts from it (qualified by valid)
//   data_in - observed N_BITS-wide count word
// Modports: master drives the sample, slave (the checker) observes it.
interface onehot_seq_checker_if #(
    parameter int N_BITS = 4
);
    logic              valid;
    logic              load;
    logic [N_BITS-1:0] data_in;

    modport master (output valid, output load, output data_in);
    modport slave  (input  valid, input  load, input  data_in);
endinterface

// File: rtl/onehot_seq_checker.sv
// rtl/onehot_seq_checker.sv - lock/track checker for a rotating one-hot count word
//
// Parameters:
//   N_BITS     - width of the observed one-hot word (>= 2)
//   LOCK_COUNT - consecutive correct samples, anchor included, needed to lock (1..15)
//   ERR_CNT_W  - width of the saturating error counter
// Ports:
//   clk       - clock, all state updates on the rising edge
//   reset     - synchronous active-high reset, dominates every other input
//   smp       - sample stream (valid, load, data_in), slave side
//   clear_err - zero err_count (an error in the same cycle leaves it at 1)
//   index     - bit position of the last accepted one-hot sample
//   locked    - high while the sequence is locked
//   seq_error - one-cycle pulse on a break of a locked sequence
//   err_count - saturating count of seq_error events
module onehot_seq_checker #(
    parameter int N_BITS     = 4,
    parameter int LOCK_COUNT = 3,
    parameter int ERR_CNT_W  = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    onehot_seq_checker_if.slave       smp,
    input  logic                      clear_err,
    output logic [$clog2(N_BITS)-1:0] index,
    output logic                      locked,
    output logic                      seq_error,
    output logic [ERR_CNT_W-1:0]      err_count
);

    localparam int IDX_W = $clog2(N_BITS);
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t               state_q,    state_nxt;
    logic [N_BITS-1:0]    expected_q, expected_nxt;
    logic [CNT_W-1:0]     good_q,     good_nxt;
    logic [IDX_W-1:0]     index_q,    index_nxt;
    logic                 locked_q,   locked_nxt;
    logic                 seq_err_q,  seq_err_nxt;
    logic [ERR_CNT_W-1:0] err_q,      err_nxt;

    logic [N_BITS-1:0]    sample;
    logic                 is_onehot;
    logic [IDX_W-1:0]     bit_pos;
    logic [N_BITS-1:0]    sample_rotl;
    logic                 err_hit;

    always_comb begin
        sample      = smp.data_in;
        // x & (x-1) clears the lowest set bit, so zero means at most one bit set.
        is_onehot   = (sample != '0) && ((sample & (sample - N_BITS'(1))) == '0);
        sample_rotl = {sample[N_BITS-2:0], sample[N_BITS-1]};
        bit_pos     = '0;
        for (int i = 0; i < N_BITS; i++) begin
            if (sample[i]) begin
                bit_pos = IDX_W'(i);
            end
        end
    end

    always_comb begin
        state_nxt    = state_q;
        expected_nxt = expected_q;
        good_nxt     = good_q;
        index_nxt    = index_q;
        seq_err_nxt  = 1'b0;
        err_hit      = 1'b0;

        if (smp.valid) begin
            if (is_onehot) begin
                index_nxt = bit_pos;
            end

            if (smp.load || (state_q == HUNT)) begin
                // Fresh start: anchor on a one-hot word, otherwise keep hunting.
                if (is_onehot) begin
                    expected_nxt = sample_rotl;
                    good_nxt     = CNT_W'(1);
                    state_nxt    = (LOCK_COUNT == 1) ? LOCKED : CHECK;
                end else begin
                    good_nxt  = '0;
                    state_nxt = HUNT;
                end
            end else if (sample == expected_q) begin
                // expected_q is always one-hot outside HUNT, so a match is one-hot too.
                expected_nxt = sample_rotl;
                if (state_q == CHECK) begin
                    good_nxt = good_q + CNT_W'(1);
                    if ((good_q + CNT_W'(1)) >= CNT_W'(LOCK_COUNT)) begin
                        state_nxt = LOCKED;
                    end
                end
            end else begin
                // Only a broken lock is an error; in CHECK it just restarts.
                err_hit = (state_q == LOCKED);
                if (is_onehot) begin
                    expected_nxt = sample_rotl;
                    good_nxt     = CNT_W'(1);
                    state_nxt    = (LOCK_COUNT == 1) ? LOCKED : CHECK;
                end else begin
                    good_nxt  = '0;
                    state_nxt = HUNT;
                end
            end
        end

        seq_err_nxt = err_hit;
        locked_nxt  = (state_nxt == LOCKED);

        err_nxt = err_q;
        if (clear_err) begin
            err_nxt = err_hit ? ERR_CNT_W'(1) : '0;
        end else if (err_hit && (err_q != '1)) begin
            err_nxt = err_q + ERR_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= HUNT;
            expected_q <= '0;
            good_q     <= '0;
            index_q    <= '0;
            locked_q   <= 1'b0;
            seq_err_q  <= 1'b0;
            err_q      <= '0;
        end else begin
            state_q    <= state_nxt;
            expected_q <= expected_nxt;
            good_q     <= good_nxt;
            index_q    <= index_nxt;
            locked_q   <= locked_nxt;
            seq_err_q  <= seq_err_nxt;
            err_q      <= err_nxt;
        end
    end

    assign index     = index_q;
    assign locked    = locked_q;
    assign seq_error = seq_err_q;
    assign err_count = err_q;

endmodule

// File: tb/tb_onehot_seq_checker.sv
// tb/tb_onehot_seq_checker.sv - directed self-checking bench for onehot_seq_checker
module tb_onehot_seq_checker;

    logic clk;
    logic reset;
    logic clear_err;

    logic [1:0] index_a,  index_b;
    logic       locked_a, locked_b;
    logic       serr_a,   serr_b;
    logic [7:0] errc_a;
    logic [1:0] errc_b;

    int n_vec;
    int n_err;

    onehot_seq_checker_if #(.N_BITS(4)) smp ();

    onehot_seq_checker #(.N_BITS(4), .LOCK_COUNT(3), .ERR_CNT_W(8)) dut_a (
        .clk       (clk),
        .reset     (reset),
        .smp       (smp),
        .clear_err (clear_err),
        .index     (index_a),
        .locked    (locked_a),
        .seq_error (serr_a),
        .err_count (errc_a)
    );

    onehot_seq_checker #(.N_BITS(4), .LOCK_COUNT(3), .ERR_CNT_W(2)) dut_b (
        .clk       (clk),
        .reset     (reset),
        .smp       (smp),
        .clear_err (clear_err),
        .index     (index_b),
        .locked    (locked_b),
        .seq_error (serr_b),
        .err_count (errc_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present one sample for one cycle, then sample outputs 1 time unit after the edge.
    task automatic step(input logic v, input logic l, input logic [3:0] d, input logic clr);
        @(negedge clk);
        smp.valid   = v;
        smp.load    = l;
        smp.data_in = d;
        clear_err   = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_a(input string tag, input logic [1:0] idx, input logic lk,
                            input logic se, input logic [7:0] ec);
        check({tag, ".index"},  32'(index_a),  32'(idx));
        check({tag, ".locked"}, 32'(locked_a), 32'(lk));
        check({tag, ".seq_err"}, 32'(serr_a),  32'(se));
        check({tag, ".err_cnt"}, 32'(errc_a),  32'(ec));
    endtask

    // From HUNT: 0001 anchors, 0010 and 0100 complete a lock of 3.
    task automatic lock_from_hunt();
        step(1'b1, 1'b0, 4'b0001, 1'b0);
        step(1'b1, 1'b0, 4'b0010, 1'b0);
        step(1'b1, 1'b0, 4'b0100, 1'b0);
    endtask

    initial begin
        n_vec       = 0;
        n_err       = 0;
        reset       = 1'b1;
        clear_err   = 1'b0;
        smp.valid   = 1'b0;
        smp.load    = 1'b0;
        smp.data_in = 4'b0000;

        // Reset with a sample present: it must be discarded.
        step(1'b1, 1'b0, 4'b1000, 1'b1);
        step(1'b1, 1'b0, 4'b1000, 1'b0);
        expect_a("rst", 2'd0, 1'b0, 1'b0, 8'd0);
        check("rst.b_err", 32'(errc_b), 32'd0);
        reset = 1'b0;

        // Acquire lock: 0001, 0010, 0100.
        step(1'b1, 1'b0, 4'b0001, 1'b0);
        expect_a("acq0", 2'd0, 1'b0, 1'b0, 8'd0);
        step(1'b1, 1'b0, 4'b0010, 1'b0);
        expect_a("acq1", 2'd1, 1'b0, 1'b0, 8'd0);
        step(1'b1, 1'b0, 4'b0100, 1'b0);
        expect_a("acq2", 2'd2, 1'b1, 1'b0, 8'd0);
        step(1'b1, 1'b0, 4'b1000, 1'b0);
        expect_a("lk3", 2'd3, 1'b1, 1'b0, 8'd0);

        // Out-of-order one-hot while locked: error, re-anchor into CHECK.
        step(1'b1, 1'b0, 4'b0010, 1'b0);
        expect_a("ooo", 2'd1, 1'b0, 1'b1, 8'd1);
        step(1'b0, 1'b0, 4'b1111, 1'b0);
        expect_a("idle", 2'd1, 1'b0, 1'b0, 8'd1);
        step(1'b1, 1'b0, 4'b0100, 1'b0);
        expect_a("rea1", 2'd2, 1'b0, 1'b0, 8'd1);
        step(1'b1, 1'b0, 4'b1000, 1'b0);
        expect_a("rea2", 2'd3, 1'b1, 1'b0, 8'd1);

        // Load while locked, out of order: no error, lock dropped.
        step(1'b1, 1'b1, 4'b0100, 1'b0);
        expect_a("load", 2'd2, 1'b0, 1'b0, 8'd1);
        step(1'b1, 1'b0, 4'b1000, 1'b0);
        expect_a("load1", 2'd3, 1'b0, 1'b0, 8'd1);
        step(1'b1, 1'b0, 4'b0001, 1'b0);
        expect_a("load2", 2'd0, 1'b1, 1'b0, 8'd1);

        // Multi-bit sample while locked: error into HUNT; index holds.
        step(1'b1, 1'b0, 4'b0011, 1'b0);
        expect_a("multi", 2'd0, 1'b0, 1'b1, 8'd2);
        step(1'b1, 1'b0, 4'b0000, 1'b0);
        expect_a("zero", 2'd0, 1'b0, 1'b0, 8'd2);
        check("zero.b_err", 32'(errc_b), 32'd2);

        // Five more locked errors: narrow counter saturates at 3, wide one keeps counting.
        for (int k = 1; k <= 5; k++) begin
            lock_from_hunt();
            check($sformatf("sat%0d.locked", k), 32'(locked_b), 32'd1);
            step(1'b1, 1'b0, 4'b0011, 1'b0);
            check($sformatf("sat%0d.b_seq", k), 32'(serr_b), 32'd1);
            check($sformatf("sat%0d.b_err", k), 32'(errc_b), (2 + k > 3) ? 32'd3 : 32'(2 + k));
            check($sformatf("sat%0d.a_err", k), 32'(errc_a), 32'(2 + k));
        end

        // clear_err together with an error leaves the count at 1.
        lock_from_hunt();
        step(1'b1, 1'b0, 4'b0011, 1'b1);
        check("clr_err.b_err", 32'(errc_b), 32'd1);
        check("clr_err.a_err", 32'(errc_a), 32'd1);
        check("clr_err.b_seq", 32'(serr_b), 32'd1);
        step(1'b0, 1'b0, 4'b0000, 1'b1);
        check("clr.b_err", 32'(errc_b), 32'd0);
        check("clr.a_err", 32'(errc_a), 32'd0);

        // Reset while locked with a matching sample: everything back to zero.
        lock_from_hunt();
        check("pre_rst.locked", 32'(locked_a), 32'd1);
        step(1'b0, 1'b0, 4'b0000, 1'b0);
        step(1'b1, 1'b0, 4'b0011, 1'b0);
        check("pre_rst.err", 32'(errc_a), 32'd1);
        lock_from_hunt();
        reset = 1'b1;
        step(1'b1, 1'b0, 4'b1000, 1'b0);
        reset = 1'b0;
        expect_a("mid_rst", 2'd0, 1'b0, 1'b0, 8'd0);
        check("mid_rst.b_lock", 32'(locked_b), 32'd0);
        // Had the 1000 been taken, 0001 would continue; from HUNT it only anchors.
        step(1'b1, 1'b0, 4'b0001, 1'b0);
        expect_a("post_rst0", 2'd0, 1'b0, 1'b0, 8'd0);
        step(1'b1, 1'b0, 4'b0010, 1'b0);
        expect_a("post_rst1", 2'd1, 1'b0, 1'b0, 8'd0);
        step(1'b1, 1'b0, 4'b0100, 1'b0);
        expect_a("post_rst2", 2'd2, 1'b1, 1'b0, 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
